// File: rtl/dom_mask_harness.sv
// Host-side share generator / unmasker for a masked DOM gadget under test.
// Encodes plaintext operands into Boolean shares, waits the gadget latency, then recombines the output shares.
module dom_mask_harness #(
    parameter int WIDTH      = 1,
    parameter int SHARES     = 3,
    parameter int GADGET_LAT = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                in_a,
    input  logic [WIDTH-1:0]                in_b,
    input  logic [2*(SHARES-1)*WIDTH-1:0]   mask_rnd,
    output logic [SHARES*WIDTH-1:0]         g_a,
    output logic [SHARES*WIDTH-1:0]         g_b,
    input  logic [SHARES*WIDTH-1:0]         g_c,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WIDTH-1:0]                out_c,
    output logic                            busy
);

    localparam int SW    = SHARES * WIDTH;
    localparam int MW    = (SHARES - 1) * WIDTH;
    localparam int CNT_W = (GADGET_LAT > 0) ? $clog2(GADGET_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GADGET_LAT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_UNMASK = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]      g_a_q, g_a_d;
    logic [SW-1:0]      g_b_q, g_b_d;
    logic [SW-1:0]      c_q, c_d;
    logic [WIDTH-1:0]   out_c_q, out_c_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    // Share 0 absorbs the plaintext; shares 1..SHARES-1 are the raw fresh masks.
    function automatic logic [SW-1:0] encode_shares(input logic [WIDTH-1:0] plain,
                                                    input logic [MW-1:0]    masks);
        logic [SW-1:0]    sh;
        logic [WIDTH-1:0] acc;
        sh  = {SW{1'b0}};
        acc = plain;
        for (int s = 1; s < SHARES; s++) begin
            sh[s*WIDTH +: WIDTH] = masks[(s-1)*WIDTH +: WIDTH];
            acc                  = acc ^ masks[(s-1)*WIDTH +: WIDTH];
        end
        sh[WIDTH-1:0] = acc;
        return sh;
    endfunction

    // Recombines shares; only ever applied to the captured register.
    function automatic logic [WIDTH-1:0] xor_shares(input logic [SW-1:0] sh);
        logic [WIDTH-1:0] acc;
        acc = {WIDTH{1'b0}};
        for (int s = 0; s < SHARES; s++) begin
            acc = acc ^ sh[s*WIDTH +: WIDTH];
        end
        return acc;
    endfunction

    // Next-state and datapath update for the encode / wait / unmask / hand-off sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        g_a_d       = g_a_q;
        g_b_d       = g_b_q;
        c_d         = c_q;
        out_c_d     = out_c_q;
        out_valid_d = out_valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    g_a_d   = encode_shares(in_a, mask_rnd[MW-1:0]);
                    g_b_d   = encode_shares(in_b, mask_rnd[2*MW-1:MW]);
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_MAX) begin
                    c_d     = g_c;
                    state_d = ST_UNMASK;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_UNMASK: begin
                out_c_d     = xor_shares(c_q);
                out_valid_d = 1'b1;
                g_a_d       = {SW{1'b0}};
                g_b_d       = {SW{1'b0}};
                c_d         = {SW{1'b0}};
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_c_d     = {WIDTH{1'b0}};
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);
    end

    // State and output registers; reset clears every share-carrying flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            g_a_q       <= {SW{1'b0}};
            g_b_q       <= {SW{1'b0}};
            c_q         <= {SW{1'b0}};
            out_c_q     <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            g_a_q       <= g_a_d;
            g_b_q       <= g_b_d;
            c_q         <= c_d;
            out_c_q     <= out_c_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign g_a       = g_a_q;
    assign g_b       = g_b_q;
    assign out_c     = out_c_q;
    assign out_valid = out_valid_q;

endmodule
